// File: rtl/wts_timer_pkg.sv
// Shared types and constants for the wave-table timer pair.
// Provides the channel FSM encoding and the period/address widths.
package wts_timer_pkg;

    localparam int unsigned PERIOD_W = 12;
    localparam int unsigned ADDR_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic [PERIOD_W-1:0] period_t;
    typedef logic [ADDR_W-1:0]   addr_t;

endpackage

// File: rtl/wts_timer_counter_if.sv
// Register-side inputs and interrupt-side outputs of both timer channels.
// master: register file / interrupt latch side; slave: the timer block.
interface wts_timer_counter_if;
    import wts_timer_pkg::*;

    period_t reg_timer1_period;
    logic    reg_timer1_start;
    logic    reg_timer1_repeat;
    logic    timer1_trigger;
    addr_t   timer1_address;
    period_t timer1_count;

    period_t reg_timer2_period;
    logic    reg_timer2_start;
    logic    reg_timer2_repeat;
    logic    timer2_trigger;
    addr_t   timer2_address;
    period_t timer2_count;

    modport master (
        output reg_timer1_period, reg_timer1_start, reg_timer1_repeat,
        output reg_timer2_period, reg_timer2_start, reg_timer2_repeat,
        input  timer1_trigger, timer1_address, timer1_count,
        input  timer2_trigger, timer2_address, timer2_count
    );

    modport slave (
        input  reg_timer1_period, reg_timer1_start, reg_timer1_repeat,
        input  reg_timer2_period, reg_timer2_start, reg_timer2_repeat,
        output timer1_trigger, timer1_address, timer1_count,
        output timer2_trigger, timer2_address, timer2_count
    );

endinterface

// File: rtl/wts_timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, down-counter, expiry sequence.
// Ports: clk, nreset, tick_i, period_i, start_i, repeat_i in;
//        trigger_o (1-clk pulse), address_o (expiry seq), count_o out.
module wts_timer_channel
    import wts_timer_pkg::*;
(
    input  logic    clk,
    input  logic    nreset,
    input  logic    tick_i,
    input  period_t period_i,
    input  logic    start_i,
    input  logic    repeat_i,
    output logic    trigger_o,
    output addr_t   address_o,
    output period_t count_o
);

    state_e  state_q;
    period_t count_q;
    addr_t   seq_q;
    addr_t   addr_q;
    logic    trig_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            seq_q   <= '0;
            addr_q  <= '0;
            trig_q  <= 1'b0;
        end else if (!start_i) begin
            // Stop wins over everything, including a coincident expiry.
            state_q <= ST_IDLE;
            count_q <= '0;
            seq_q   <= '0;
            addr_q  <= '0;
            trig_q  <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // Load has priority over a tick on the same edge.
                    state_q <= ST_RUN;
                    count_q <= period_i;
                    seq_q   <= '0;
                end
                ST_RUN: begin
                    if (tick_i) begin
                        if (count_q != '0) begin
                            count_q <= count_q - 1'b1;
                        end else begin
                            trig_q <= 1'b1;
                            addr_q <= seq_q;
                            seq_q  <= seq_q + 1'b1;
                            if (repeat_i) begin
                                count_q <= period_i;
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    count_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign trigger_o = trig_q;
    assign address_o = addr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/wts_timer_counter.sv
// Timer pair top: shared free-running prescaler plus two channels.
// Ports: clk, nreset (async, active-low), bus (slave modport).
module wts_timer_counter
    import wts_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 256
) (
    input  logic                clk,
    input  logic                nreset,
    wts_timer_counter_if.slave  bus
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick_q;
    logic          tick_d;

    assign tick_d = (pre_q == PRE_LAST);
    assign pre_d  = tick_d ? '0 : pre_q + 1'b1;

    // tick is high in the cycle after pre hits its last value.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    wts_timer_channel u_ch1 (
        .clk       (clk),
        .nreset    (nreset),
        .tick_i    (tick_q),
        .period_i  (bus.reg_timer1_period),
        .start_i   (bus.reg_timer1_start),
        .repeat_i  (bus.reg_timer1_repeat),
        .trigger_o (bus.timer1_trigger),
        .address_o (bus.timer1_address),
        .count_o   (bus.timer1_count)
    );

    wts_timer_channel u_ch2 (
        .clk       (clk),
        .nreset    (nreset),
        .tick_i    (tick_q),
        .period_i  (bus.reg_timer2_period),
        .start_i   (bus.reg_timer2_start),
        .repeat_i  (bus.reg_timer2_repeat),
        .trigger_o (bus.timer2_trigger),
        .address_o (bus.timer2_address),
        .count_o   (bus.timer2_count)
    );

endmodule
